// File: rtl/alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: ALU op encoding and FSM state codes.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [1:0] BEZCZYNNY = 2'd0;
    localparam logic [1:0] LICZ      = 2'd1;
    localparam logic [1:0] GOTOWE    = 2'd2;

    function automatic logic parzystosc8(input logic [7:0] bajt);
        return ^bajt;
    endfunction

endpackage

// File: rtl/alu_flagi.sv
// Flag accumulation for the sequencer: carry chain register, Z AND-chain and result parity XOR.
module alu_flagi
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       cin_i,
    input  logic       step_i,
    input  logic       last_i,
    input  logic       alu_c_i,
    input  logic       alu_z_i,
    input  logic [7:0] wynik_bajt_i,
    output logic       carry_o,
    output logic       z_nxt_o,
    output logic       par_nxt_o
);

    logic carry_q, carry_d;
    logic z_acc_q, z_acc_d;
    logic par_q, par_d;

    assign carry_o   = carry_q;
    assign z_nxt_o   = z_acc_q & alu_z_i;
    assign par_nxt_o = par_q ^ parzystosc8(wynik_bajt_i);

    always_comb begin
        carry_d = carry_q;
        z_acc_d = z_acc_q;
        par_d   = par_q;
        if (clear_i) begin
            carry_d = cin_i;
            z_acc_d = 1'b1;
            par_d   = 1'b0;
        end else if (step_i) begin
            // Carry drives alu_bitP directly, so it keeps the last value sent after the final byte.
            if (!last_i) begin
                carry_d = alu_c_i;
            end
            z_acc_d = z_nxt_o;
            par_d   = par_nxt_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            z_acc_q <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            z_acc_q <= z_acc_d;
            par_q   <= par_d;
        end
    end

endmodule

// File: rtl/alu_sekwencer.sv
// Multi-byte sequencer around an external 8-bit ALU, one byte per cycle from the LSB.
// Optional ALU_SEKW_AKUM_EN adds uzyj_akum_i to take operand A from the current result.
module alu_sekwencer
    import alu_pkg::*;
#(
    parameter int unsigned BAJTY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 gotowy_o,
    input  logic [1:0]           op_i,
    input  logic [8*BAJTY-1:0]   arg_a_i,
    input  logic [8*BAJTY-1:0]   arg_b_i,
    input  logic                 przen_we_i,
`ifdef ALU_SEKW_AKUM_EN
    input  logic                 uzyj_akum_i,
`endif
    output logic [7:0]           alu_a_o,
    output logic [7:0]           alu_b_o,
    output logic [1:0]           alu_wybor_o,
    output logic                 alu_bitp_o,
    input  logic [7:0]           alu_wynik_i,
    input  logic                 alu_c_i,
    input  logic                 alu_z_i,
    input  logic                 alu_ov_i,
    output logic [8*BAJTY-1:0]   wynik_o,
    output logic                 c_o,
    output logic                 z_o,
    output logic                 ov_o,
    output logic                 even_o,
    output logic                 wazny_o
);

    localparam int unsigned W  = 8 * BAJTY;
    localparam int unsigned KW = (BAJTY > 1) ? $clog2(BAJTY) : 1;
    localparam logic [KW-1:0] K_OST = KW'(BAJTY - 1);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  wynik_q, wynik_d;
    logic          c_q, c_d, z_q, z_d, ov_q, ov_d, even_q, even_d;
    logic [7:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]    alu_wybor_q, alu_wybor_d;

    logic          akcept, krok, ostatni;
    logic          z_nxt, par_nxt;
    logic [W-1:0]  arg_a_sel;

    assign akcept  = start_i && (state_q == BEZCZYNNY);
    assign krok    = (state_q == LICZ);
    assign ostatni = (k_q == K_OST);

`ifdef ALU_SEKW_AKUM_EN
    assign arg_a_sel = uzyj_akum_i ? wynik_q : arg_a_i;
`else
    assign arg_a_sel = arg_a_i;
`endif

    alu_flagi u_flagi (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (akcept),
        .cin_i        (przen_we_i),
        .step_i       (krok),
        .last_i       (ostatni),
        .alu_c_i      (alu_c_i),
        .alu_z_i      (alu_z_i),
        .wynik_bajt_i (alu_wynik_i),
        .carry_o      (alu_bitp_o),
        .z_nxt_o      (z_nxt),
        .par_nxt_o    (par_nxt)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        sh_d        = sh_q;
        wynik_d     = wynik_q;
        c_d         = c_q;
        z_d         = z_q;
        ov_d        = ov_q;
        even_d      = even_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_wybor_d = alu_wybor_q;

        unique case (state_q)
            BEZCZYNNY: begin
                if (akcept) begin
                    // Byte 0 goes to the ALU right away; the rest wait in shift registers.
                    alu_a_d     = arg_a_sel[7:0];
                    alu_b_d     = arg_b_i[7:0];
                    alu_wybor_d = op_i;
                    a_d         = arg_a_sel >> 8;
                    b_d         = arg_b_i >> 8;
                    k_d         = '0;
                    state_d     = LICZ;
                end
            end
            LICZ: begin
                sh_d[{k_q, 3'b000} +: 8] = alu_wynik_i;
                if (ostatni) begin
                    wynik_d = sh_d;
                    c_d     = alu_c_i;
                    ov_d    = alu_ov_i;
                    z_d     = z_nxt;
                    even_d  = par_nxt;
                    k_d     = '0;
                    state_d = GOTOWE;
                end else begin
                    alu_a_d = a_q[7:0];
                    alu_b_d = b_q[7:0];
                    a_d     = a_q >> 8;
                    b_d     = b_q >> 8;
                    k_d     = k_q + 1'b1;
                end
            end
            GOTOWE: begin
                state_d = BEZCZYNNY;
            end
            default: begin
                state_d = BEZCZYNNY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BEZCZYNNY;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            wynik_q     <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            ov_q        <= 1'b0;
            even_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_wybor_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sh_q        <= sh_d;
            wynik_q     <= wynik_d;
            c_q         <= c_d;
            z_q         <= z_d;
            ov_q        <= ov_d;
            even_q      <= even_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_wybor_q <= alu_wybor_d;
        end
    end

    assign gotowy_o    = (state_q == BEZCZYNNY);
    assign wazny_o     = (state_q == GOTOWE);
    assign wynik_o     = wynik_q;
    assign c_o         = c_q;
    assign z_o         = z_q;
    assign ov_o        = ov_q;
    assign even_o      = even_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_wybor_o = alu_wybor_q;

endmodule

// File: tb/tb_alu_sekwencer.sv
// Directed bench for alu_sekwencer (BAJTY=2) with a behavioural 8-bit ALU in the loop.
module tb_alu_sekwencer;

    localparam int unsigned BAJTY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        gotowy;
    logic [1:0]  op = 2'b00;
    logic [15:0] arg_a = '0, arg_b = '0;
    logic        przen_we = 1'b0;
    logic        uzyj_akum = 1'b0;
    logic [7:0]  alu_a, alu_b, alu_wynik;
    logic [1:0]  alu_wybor;
    logic        alu_bitp, alu_c, alu_z, alu_ov;
    logic [15:0] wynik;
    logic        c, z, ov, even, wazny;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] last_w = '0;

    always #5 clk = ~clk;

    alu_sekwencer #(.BAJTY(BAJTY)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .gotowy_o    (gotowy),
        .op_i        (op),
        .arg_a_i     (arg_a),
        .arg_b_i     (arg_b),
        .przen_we_i  (przen_we),
`ifdef ALU_SEKW_AKUM_EN
        .uzyj_akum_i (uzyj_akum),
`endif
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_wybor_o (alu_wybor),
        .alu_bitp_o  (alu_bitp),
        .alu_wynik_i (alu_wynik),
        .alu_c_i     (alu_c),
        .alu_z_i     (alu_z),
        .alu_ov_i    (alu_ov),
        .wynik_o     (wynik),
        .c_o         (c),
        .z_o         (z),
        .ov_o        (ov),
        .even_o      (even),
        .wazny_o     (wazny)
    );

    // External 8-bit ALU model
    logic [8:0] sum9;
    always_comb begin
        sum9      = '0;
        alu_wynik = '0;
        alu_c     = 1'b0;
        alu_ov    = 1'b0;
        case (alu_wybor)
            2'b00: begin
                sum9      = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_bitp};
                alu_wynik = sum9[7:0];
                alu_c     = sum9[8];
                alu_ov    = (alu_a[7] == alu_b[7]) && (alu_wynik[7] != alu_a[7]);
            end
            2'b01: begin
                sum9      = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_bitp};
                alu_wynik = sum9[7:0];
                alu_c     = sum9[8];
                alu_ov    = (alu_a[7] != alu_b[7]) && (alu_wynik[7] != alu_a[7]);
            end
            2'b10:   alu_wynik = alu_a | alu_b;
            default: alu_wynik = alu_a & alu_b;
        endcase
        alu_z = (alu_wynik == 8'h00);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency, hold of old result during LICZ, flags and pulse width.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic akum,
                          input logic [15:0] ew, input logic ec, input logic ez,
                          input logic eov, input logic eev);
        int lat;
        lat = -1;
        @(negedge clk);
        check_eq({tag, ".gotowy_pre"}, gotowy, 1);
        start = 1'b1; op = o; arg_a = a; arg_b = b; przen_we = cin; uzyj_akum = akum;
        @(posedge clk);
        #1 start = 1'b0; uzyj_akum = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wazny) begin
                lat = i;
                break;
            end
            if (i == BAJTY - 1) check_eq({tag, ".hold"}, wynik, last_w);
        end
        check_eq({tag, ".lat"}, lat, BAJTY);
        check_eq({tag, ".wynik"}, wynik, ew);
        check_eq({tag, ".flags"}, {c, z, ov, even}, {ec, ez, eov, eev});
        @(negedge clk);
        check_eq({tag, ".pulse"}, {wazny, gotowy}, 2'b01);
        last_w = ew;
    endtask

    initial begin
        int cnt;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.outs", {wynik, c, z, ov, even, wazny, gotowy}, {16'h0, 6'b000001});
        check_eq("rst.alu", {alu_a, alu_b, alu_wybor, alu_bitp}, 19'h0);

        run_op("add1", 2'b00, 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0, 1);
        run_op("add2", 2'b00, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 1, 0, 0);
        run_op("add3", 2'b00, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 0, 1, 1);
        run_op("addc", 2'b00, 16'h1234, 16'h1111, 1, 0, 16'h2346, 0, 0, 0, 0);
        run_op("sub1", 2'b01, 16'h0005, 16'h0003, 0, 0, 16'h0002, 0, 0, 0, 1);
        run_op("sub2", 2'b01, 16'h0000, 16'h0001, 0, 0, 16'hFFFF, 1, 0, 0, 0);
        run_op("subb", 2'b01, 16'h0100, 16'h0000, 1, 0, 16'h00FF, 0, 0, 0, 0);
        run_op("or",   2'b10, 16'h0F0F, 16'hF000, 0, 0, 16'hFF0F, 0, 0, 0, 0);
        run_op("and",  2'b11, 16'h0F0F, 16'hF000, 0, 0, 16'h0000, 0, 1, 0, 0);

        // start pulsed during LICZ must be dropped
        @(negedge clk);
        start = 1'b1; op = 2'b00; arg_a = 16'h00FF; arg_b = 16'h0001; przen_we = 1'b0;
        @(posedge clk);
        #1 arg_a = 16'h1111; arg_b = 16'h1111;
        @(posedge clk);
        #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wazny) begin
                cnt++;
                check_eq("ign.wynik", wynik, 16'h0100);
            end
        end
        check_eq("ign.count", cnt, 1);
        check_eq("ign.gotowy", gotowy, 1);

        // reset one cycle into LICZ
        @(negedge clk);
        start = 1'b1; op = 2'b00; arg_a = 16'h1234; arg_b = 16'h1111; przen_we = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst.outs", {wynik, c, z, ov, even, wazny, gotowy}, {16'h0, 6'b000001});
        check_eq("arst.alu", {alu_a, alu_b, alu_wybor, alu_bitp}, 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wazny) cnt++;
        end
        check_eq("arst.nowazny", cnt, 0);
        check_eq("arst.gotowy", gotowy, 1);
        last_w = '0;

`ifdef ALU_SEKW_AKUM_EN
        run_op("akum1", 2'b00, 16'h0010, 16'h0001, 0, 0, 16'h0011, 0, 0, 0, 0);
        run_op("akum2", 2'b00, 16'hFFFF, 16'h0001, 0, 1, 16'h0012, 0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
